// File: rtl/fixed_pri_arbiter_pkg.sv
// Shared helpers and defaults for the fixed-priority arbiter.
// Helpers work on MAX_N-wide vectors; callers zero-extend narrower request vectors.
package fixed_pri_arbiter_pkg;

  localparam int DEF_N         = 8;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_STARVE_TH = 16;
  localparam int MAX_N         = 64;
  localparam int MAX_IDX_W     = $clog2(MAX_N);

  // Isolates the lowest set bit (two's-complement trick), zero when vec is zero.
  function automatic logic [MAX_N-1:0] lowest_set_onehot(input logic [MAX_N-1:0] vec);
    return vec & (~vec + 1'b1);
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] onehot,
                                                         input int width);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < width && onehot[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_pri_wait_cnt.sv
// One requester's saturating wait counter and registered starvation flag.
module fixed_pri_wait_cnt #(
  parameter int CNT_W     = 8,
  parameter int STARVE_TH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic starve
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(STARVE_TH);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             starve_reg;

  always_comb begin
    cnt_next = '0;
    if (req && !gnt) begin
      cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
    end
  end

  // The flag is compared against the next count so it tracks the counter edge-for-edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      starve_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      starve_reg <= (cnt_next >= TH);
    end
  end

  assign starve = starve_reg;

endmodule

// File: rtl/fixed_pri_arbiter.sv
// N-way fixed-priority arbiter (requester 0 highest) with a combinational grant
// and a registered side-band: delayed grant, winner index and starvation flags.
module fixed_pri_arbiter
  import fixed_pri_arbiter_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int IDX_W     = $clog2(N),
  parameter int CNT_W     = DEF_CNT_W,
  parameter int STARVE_TH = DEF_STARVE_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_q,
  output logic [IDX_W-1:0] gnt_idx_q,
  output logic             gnt_valid_q,
  output logic [N-1:0]     starve
);

  logic [MAX_N-1:0]     req_ext;
  logic [MAX_N-1:0]     gnt_ext;
  logic [MAX_IDX_W-1:0] idx_full;

  assign req_ext   = MAX_N'(req);
  assign gnt_ext   = lowest_set_onehot(req_ext);
  assign idx_full  = onehot_to_idx(gnt_ext, N);
  assign gnt       = N'(gnt_ext);
  assign gnt_idx   = IDX_W'(idx_full);
  assign gnt_valid = |req;

  logic [N-1:0]     gnt_q_reg;
  logic [IDX_W-1:0] gnt_idx_q_reg;
  logic             gnt_valid_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q_reg       <= '0;
      gnt_idx_q_reg   <= '0;
      gnt_valid_q_reg <= 1'b0;
    end else begin
      gnt_q_reg       <= gnt;
      gnt_idx_q_reg   <= gnt_idx;
      gnt_valid_q_reg <= gnt_valid;
    end
  end

  assign gnt_q       = gnt_q_reg;
  assign gnt_idx_q   = gnt_idx_q_reg;
  assign gnt_valid_q = gnt_valid_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_wait
      fixed_pri_wait_cnt #(
        .CNT_W     (CNT_W),
        .STARVE_TH (STARVE_TH)
      ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .req    (req[gi]),
        .gnt    (gnt[gi]),
        .starve (starve[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fixed_pri_arbiter.sv
// Self-checking bench for fixed_pri_arbiter (N=8, CNT_W=8, STARVE_TH=16).
module tb_fixed_pri_arbiter;

  localparam int N  = 8;
  localparam int TH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt, gnt_q, starve;
  logic       gnt_valid, gnt_valid_q;
  logic [2:0] gnt_idx, gnt_idx_q;

  int checks   = 0;
  int failures = 0;

  // Reference state: consecutive denied cycles per requester and delayed grant.
  int         exp_wait [N];
  logic [7:0] exp_gnt_q;
  int         exp_idx_q;
  logic       exp_valid_q;

  fixed_pri_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx),
    .gnt_q       (gnt_q),
    .gnt_idx_q   (gnt_idx_q),
    .gnt_valid_q (gnt_valid_q),
    .starve      (starve)
  );

  always #5 clk = ~clk;

  function automatic int ref_idx(input logic [7:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] ref_gnt(input logic [7:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_starve();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < N; i++) if (exp_wait[i] >= TH) s[i] = 1'b1;
    return s;
  endfunction

  // Advance one rising edge, update the reference from the values the DUT saw, sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_gnt_q = 8'h00; exp_idx_q = 0; exp_valid_q = 1'b0;
      for (int i = 0; i < N; i++) exp_wait[i] = 0;
    end else begin
      exp_gnt_q   = ref_gnt(req);
      exp_idx_q   = ref_idx(req);
      exp_valid_q = (req != 8'h00);
      for (int i = 0; i < N; i++) begin
        if (req[i] && i != ref_idx(req)) exp_wait[i] = (exp_wait[i] < 255) ? exp_wait[i] + 1 : 255;
        else exp_wait[i] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00;
    tick(); tick();
    checks++;
    if (gnt_q !== 8'h00 || gnt_idx_q !== 3'd0 || gnt_valid_q !== 1'b0 || starve !== 8'h00) begin
      failures++;
      $display("FAIL reset: gnt_q=%h idx_q=%0d valid_q=%b starve=%h required all zero",
               gnt_q, gnt_idx_q, gnt_valid_q, starve);
    end
  endtask

  task automatic test_idle();
    req = 8'h00; #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      failures++;
      $display("FAIL idle: gnt=%h valid=%b idx=%0d required 00/0/0", gnt, gnt_valid, gnt_idx);
    end
  endtask

  task automatic test_single_sweep();
    logic [7:0] e;
    for (int i = 0; i < N; i++) begin
      e = 8'(1 << i);
      req = e; #1;
      checks++;
      if (gnt !== e || gnt_idx !== 3'(i) || gnt_valid !== 1'b1) begin
        failures++;
        $display("FAIL sweep_%0d: gnt=%h idx=%0d valid=%b required %h/%0d/1", i, gnt, gnt_idx, gnt_valid, e, i);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] vin [7]  = '{8'h03, 8'hFF, 8'hAA, 8'hF0, 8'h94, 8'h28, 8'h55};
    logic [7:0] vexp [7] = '{8'h01, 8'h01, 8'h02, 8'h10, 8'h04, 8'h08, 8'h01};
    for (int k = 0; k < 7; k++) begin
      req = vin[k]; #1;
      checks++;
      if (gnt !== vexp[k] || $countones(gnt) > 1) begin
        failures++;
        $display("FAIL priority req=%h: gnt=%h required %h", vin[k], gnt, vexp[k]);
      end
    end
  endtask

  task automatic test_random_comb();
    logic [7:0] r;
    for (int k = 0; k < 1004; k++) begin
      r = 8'($urandom);
      if (k % 3 == 0) r = r & 8'($urandom) & 8'($urandom);
      req = r; #1;
      checks++;
      if (gnt !== ref_gnt(r) || gnt_idx !== 3'(ref_idx(r)) || gnt_valid !== (r != 8'h00)
          || $countones(gnt) > 1) begin
        failures++;
        $display("FAIL random_comb req=%h: gnt=%h idx=%0d valid=%b required %h/%0d/%b",
                 r, gnt, gnt_idx, gnt_valid, ref_gnt(r), ref_idx(r), r != 8'h00);
      end
    end
  endtask

  task automatic test_clocked();
    rst = 1'b0; req = 8'h0C;
    tick();
    checks++;
    if (gnt_q !== 8'h04 || gnt_idx_q !== 3'd2 || gnt_valid_q !== 1'b1) begin
      failures++;
      $display("FAIL clocked: gnt_q=%h idx_q=%0d valid_q=%b required 04/2/1", gnt_q, gnt_idx_q, gnt_valid_q);
    end
  endtask

  task automatic test_starvation();
    req = 8'h03;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (starve[1] !== (k >= TH) || starve[0] !== 1'b0) begin
        failures++;
        $display("FAIL starve_rise edge %0d: starve=%h required bit1=%b bit0=0", k, starve, k >= TH);
      end
    end
    req = 8'h01;
    tick();
    checks++;
    if (starve !== 8'h00) begin
      failures++;
      $display("FAIL starve_clear: starve=%h required 00", starve);
    end
  endtask

  task automatic test_reset_mid();
    req = 8'h03;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1; #1;
    checks++;
    if (gnt !== 8'h01 || gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_gnt: gnt=%h valid=%b required 01/1", gnt, gnt_valid);
    end
    tick();
    checks++;
    if (starve !== 8'h00 || gnt_q !== 8'h00 || gnt_valid_q !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state: starve=%h gnt_q=%h valid_q=%b required 00/00/0", starve, gnt_q, gnt_valid_q);
    end
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (starve[1] !== (k >= TH)) begin
        failures++;
        $display("FAIL reset_mid_recount edge %0d: starve=%h required bit1=%b", k, starve, k >= TH);
      end
    end
  endtask

  task automatic test_random_clocked();
    logic [7:0] keep;
    keep = 8'h01;
    for (int k = 0; k < 600; k++) begin
      if (k % 40 == 0) keep = 8'($urandom) | 8'h01;
      req = 8'($urandom) | keep;
      rst = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (gnt_q !== exp_gnt_q || gnt_idx_q !== 3'(exp_idx_q) || gnt_valid_q !== exp_valid_q
          || starve !== ref_starve()) begin
        failures++;
        $display("FAIL random_clocked cyc %0d: gnt_q=%h idx_q=%0d valid_q=%b starve=%h required %h/%0d/%b/%h",
                 k, gnt_q, gnt_idx_q, gnt_valid_q, starve, exp_gnt_q, exp_idx_q, exp_valid_q, ref_starve());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    for (int i = 0; i < N; i++) exp_wait[i] = 0;
    exp_gnt_q = 8'h00; exp_idx_q = 0; exp_valid_q = 1'b0;
    test_reset();
    test_idle();
    test_single_sweep();
    test_priority();
    test_random_comb();
    test_clocked();
    test_starvation();
    test_reset_mid();
    test_random_clocked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_pri_arbiter.md
Name: fixed_pri_arbiter

Overview:
Parameterised N-way fixed-priority arbiter: requester 0 has the highest priority and requester N-1 the lowest. The grant path is purely combinational (zero latency). A clocked side-band provides a registered copy of the grant, the winner index and per-requester starvation flags. It is used wherever shared-resource access needs a deterministic priority rather than fairness.

Parameters:
N, 8, number of requesters (N >= 2).
IDX_W, $clog2(N), width of the winner-index outputs (derived; not overridden).
CNT_W, 8, width of each per-requester wait counter.
STARVE_TH, 16, consecutive denied-request cycles at which a starve flag asserts (1 <= STARVE_TH <= 2**CNT_W-1).

Ports:
clk  input  1  clock; all registers update on the rising edge
rst  input  1  synchronous, active-high reset
req  input  N  request vector; bit i = requester i
gnt  output  N  combinational one-hot (or zero) grant
gnt_valid  output  1  combinational; equals |req
gnt_idx  output  IDX_W  combinational binary index of the granted bit; 0 when gnt_valid=0
gnt_q  output  N  gnt registered one cycle
gnt_idx_q  output  IDX_W  gnt_idx registered one cycle
gnt_valid_q  output  1  gnt_valid registered one cycle
starve  output  N  bit i high while requester i's wait count >= STARVE_TH

Behaviour:
- gnt = lowest-index set bit of req (req & (~req + 1)); all zero when req == 0.
- gnt is never multi-hot: $countones(gnt) <= 1 always.
- gnt, gnt_valid and gnt_idx depend only on req. They are independent of clk and rst, and settle within the same delta/timestep as req. No clock is needed for correct grants.
- Registered outputs: on each rising clk edge with rst=1, gnt_q, gnt_idx_q, gnt_valid_q, all wait counters and starve clear to 0. Otherwise they load the current combinational values (latency 1 cycle).
- Wait counter i (CNT_W bits), per edge with rst=0:
  - req[i]=1 and gnt[i]=0: increment, saturating at 2**CNT_W-1.
  - otherwise: clear to 0.
- starve[i] is registered: it is high in the cycle after counter i reaches STARVE_TH and stays high while the count remains >= STARVE_TH.
- Requester 0 can never starve: its counter stays 0.
- Reset mid-operation: only the registered state clears; gnt keeps tracking req.
- X/Z on req is not supported; outputs are undefined in that case.

Decomposition:
- Package fixed_pri_arbiter_pkg holds:
  - function lowest_set_onehot(vec) returning vec & -vec;
  - function onehot_to_idx(onehot, width) returning the binary index, 0 for all-zero;
  - default localparams for N, CNT_W and STARVE_TH.
- One sub-module, fixed_pri_wait_cnt: a single saturating counter plus threshold compare, instantiated N times in a generate loop.
- The combinational grant logic stays in the top module.

Test Plan:
- req=8'h00 -> gnt=8'h00, gnt_valid=0, gnt_idx=0.
- Single-bit sweep, req=1<<i for i=0..7 -> gnt=req, gnt_idx=i. Include req=8'h80 -> gnt=8'h80, and req=8'h08 -> gnt=8'h08.
- Multi-request priority, each checked 1 time unit after req changes with no clock edge:
  - 8'h03 -> 8'h01; 8'hFF -> 8'h01; 8'hAA -> 8'h02
  - 8'hF0 -> 8'h10; 8'h94 -> 8'h04; 8'h28 -> 8'h08
  - 8'h55 -> 8'h01, and $countones(gnt) <= 1
- Random req (4+ vectors, plus 1000-vector regression) -> gnt equals the lowest set bit computed by a loop reference model; gnt is one-hot or zero.
- Clocked path: rst=1 for 2 cycles -> all _q outputs and starve = 0. Then apply req=8'h0C -> the next edge gives gnt_q=8'h04, gnt_idx_q=2, gnt_valid_q=1.
- Starvation, STARVE_TH=16: hold req=8'h03 -> starve[1] rises after 16 denied edges and starve[0] stays 0. Drop req[1] -> starve[1] clears on the following edge. Asserting rst mid-count clears the counters while gnt stays 8'h01.
